// File: rtl/encoder_fault_monitor_if.sv
// Bus between the encoder-check block, encoder_fault_monitor and the motor-control logic.
// The master drives sampling control and raw encoder inputs; the slave returns decoded sector and fault status.
interface encoder_fault_monitor_if;
  logic       enable;
  logic [7:0] uvw_data;
  logic [7:0] encoder_error_data;
  logic       fault_ack;
  logic       sample_stb;
  logic [2:0] hall_code;
  logic [2:0] sector;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] err_total;

  modport master (
    output enable, uvw_data, encoder_error_data, fault_ack,
    input  sample_stb, hall_code, sector, fault, fault_code, err_total
  );

  modport slave (
    input  enable, uvw_data, encoder_error_data, fault_ack,
    output sample_stb, hall_code, sector, fault, fault_code, err_total
  );
endinterface

// File: rtl/encoder_fault_monitor.sv
// Periodic hall/encoder-error sampler: decodes the commutation sector, counts bad samples, latches a fault.
// Define HALL_SEQ_CHECK_EN to also reject hall steps that skip a sector (fault class 11).
module encoder_fault_monitor #(
  parameter int SAMPLE_DIV  = 1000,
  parameter int FAULT_LIMIT = 4
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  encoder_fault_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FAULT} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 2);
  localparam logic [2:0]  CNT_LAST  = 3'(FAULT_LIMIT - 1);
  localparam logic [1:0]  CODE_NONE = 2'b00;
  localparam logic [1:0]  CODE_HALL = 2'b01;
  localparam logic [1:0]  CODE_ENC  = 2'b10;
  localparam logic [1:0]  CODE_SEQ  = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        prev_valid_q, prev_valid_d;
  logic        stb_q, stb_d;
  logic [2:0]  hall_q, hall_d;
  logic [2:0]  sector_q, sector_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [7:0]  err_total_q, err_total_d;

  logic [2:0]  new_code;
  logic [2:0]  new_sector;
  logic        trans_ok;
  logic [1:0]  bad_class;
  logic        trip;
  logic        unused_bits;

  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd1;
      3'b011:  return 3'd2;
      3'b010:  return 3'd3;
      3'b110:  return 3'd4;
      3'b100:  return 3'd5;
      3'b101:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  assign new_code    = bus.uvw_data[2:0];
  assign new_sector  = hall_to_sector(new_code);
  assign unused_bits = ^{bus.uvw_data[7:3], bus.encoder_error_data[7:1]};

`ifdef HALL_SEQ_CHECK_EN
  logic [2:0] sector_up;
  logic [2:0] sector_dn;
  // Only a hold or a single-sector step either way is a plausible rotor move between samples.
  assign sector_up = (sector_q == 3'd6) ? 3'd1 : sector_q + 3'd1;
  assign sector_dn = (sector_q == 3'd1) ? 3'd6 : sector_q - 3'd1;
  assign trans_ok  = !prev_valid_q || (new_sector == sector_q) ||
                     (new_sector == sector_up) || (new_sector == sector_dn);
`else
  assign trans_ok  = 1'b1;
`endif

  always_comb begin
    bad_class = CODE_NONE;
    if (bus.encoder_error_data[0]) begin
      bad_class = CODE_ENC;
    end else if (new_sector == 3'd0) begin
      bad_class = CODE_HALL;
    end else if (!trans_ok) begin
      bad_class = CODE_SEQ;
    end
  end

  assign trip = (bad_class != CODE_NONE) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      prev_valid_q <= 1'b0;
      stb_q        <= 1'b0;
      hall_q       <= '0;
      sector_q     <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
      err_total_q  <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      prev_valid_q <= prev_valid_d;
      stb_q        <= stb_d;
      hall_q       <= hall_d;
      sector_q     <= sector_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      err_total_q  <= err_total_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = WAIT;
      WAIT: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (div_q == DIV_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (trip) begin
          state_d = FAULT;
        end else if (!bus.enable) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      FAULT:   if (bus.fault_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The strobe is registered from the next state so it is high exactly during SAMPLE.
  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    prev_valid_d = prev_valid_q;
    hall_d       = hall_q;
    sector_d     = sector_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    err_total_d  = err_total_q;
    stb_d        = (state_d == SAMPLE);
    case (state_q)
      IDLE: begin
        div_d        = '0;
        cnt_d        = '0;
        prev_valid_d = 1'b0;
      end
      WAIT: div_d = div_q + 16'd1;
      SAMPLE: begin
        div_d = '0;
        if (bad_class == CODE_NONE) begin
          hall_d       = new_code;
          sector_d     = new_sector;
          prev_valid_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (err_total_q != 8'hFF) begin
            err_total_d = err_total_q + 8'd1;
          end
          if (trip) begin
            fault_d      = 1'b1;
            fault_code_d = bad_class;
          end
        end
      end
      FAULT: begin
        if (bus.fault_ack) begin
          fault_d      = 1'b0;
          fault_code_d = CODE_NONE;
        end
      end
      default: ;
    endcase
  end

  assign bus.sample_stb = stb_q;
  assign bus.hall_code  = hall_q;
  assign bus.sector     = sector_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.err_total  = err_total_q;
endmodule

// File: tb/tb_encoder_fault_monitor.sv
// Scoreboard bench for encoder_fault_monitor: stimulus queues expected results, a monitor checks each strobe.
module tb_encoder_fault_monitor;
  localparam int DIV   = 4;
  localparam int LIMIT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  encoder_fault_monitor_if bus();

  encoder_fault_monitor #(
    .SAMPLE_DIV  (DIV),
    .FAULT_LIMIT (LIMIT)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] hall;
    logic [2:0] sector;
    logic       flt;
    logic [1:0] code;
    logic [7:0] errt;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_stb_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe is matched against the oldest queued expectation after the updating edge.
  initial begin
    exp_t e;
    int   gap;
    forever begin
      @(negedge clk);
      if (rst_n && bus.sample_stb === 1'b1) begin
        gap          = cyc - last_stb_cyc;
        last_stb_cyc = cyc;
        @(posedge clk);
        #1;
        chk("stb_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("[TB] sample %s: hall=%b sector=%0d fault=%b code=%b err_total=%0d gap=%0d",
                   e.name, bus.hall_code, bus.sector, bus.fault, bus.fault_code, bus.err_total, gap);
          chk({e.name, "_hall"}, bus.hall_code, e.hall);
          chk({e.name, "_sector"}, bus.sector, e.sector);
          chk({e.name, "_fault"}, bus.fault, e.flt);
          chk({e.name, "_code"}, bus.fault_code, e.code);
          chk({e.name, "_err_total"}, bus.err_total, e.errt);
          if (e.gap > 0) chk({e.name, "_gap"}, gap, e.gap);
        end
      end
    end
  end

  task automatic smp(input string nm, input logic [2:0] uvw, input logic err,
                     input logic [2:0] hall, input logic [2:0] sec, input logic flt,
                     input logic [1:0] code, input logic [7:0] errt, input int gap,
                     input bit drop_en);
    exp_t x;
    bit   got;
    x.name = nm; x.hall = hall; x.sector = sec; x.flt = flt;
    x.code = code; x.errt = errt; x.gap = gap;
    exp_q.push_back(x);
    bus.uvw_data           = {5'b11010, uvw};
    bus.encoder_error_data = {7'b1010110, err};
    got = 1'b0;
    for (int i = 0; i < 4 * DIV + 8 && !got; i++) begin
      @(negedge clk);
      if (bus.sample_stb === 1'b1) got = 1'b1;
    end
    chk({nm, "_stb_seen"}, got, 1);
    if (!got) begin
      void'(exp_q.pop_back());
    end else begin
      if (drop_en) bus.enable = 1'b0;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_ack();
    chk("fault_before_ack", bus.fault, 1);
    bus.fault_ack = 1'b1;
    last_stb_cyc  = cyc + 1;
    @(posedge clk);
    #1;
    chk("fault_after_ack", bus.fault, 0);
    chk("code_after_ack", bus.fault_code, 0);
    bus.fault_ack = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] eh;
    logic [2:0] es;
    logic [7:0] ee;
    int         g;
    bus.enable             = 1'b0;
    bus.uvw_data           = '0;
    bus.encoder_error_data = '0;
    bus.fault_ack          = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outputs", {bus.sample_stb, bus.hall_code, bus.sector, bus.fault,
                        bus.fault_code, bus.err_total}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    bus.enable   = 1'b1;
    last_stb_cyc = cyc + 1;

    // Full forward rotation, including the 6 -> 1 wrap.
    smp("rot1", 3'b001, 0, 3'b001, 3'd1, 0, 2'b00, 8'd0, DIV - 1, 0);
    smp("rot2", 3'b011, 0, 3'b011, 3'd2, 0, 2'b00, 8'd0, DIV, 0);
    smp("rot3", 3'b010, 0, 3'b010, 3'd3, 0, 2'b00, 8'd0, DIV, 0);
    smp("rot4", 3'b110, 0, 3'b110, 3'd4, 0, 2'b00, 8'd0, DIV, 0);
    smp("rot5", 3'b100, 0, 3'b100, 3'd5, 0, 2'b00, 8'd0, DIV, 0);
    smp("rot6", 3'b101, 0, 3'b101, 3'd6, 0, 2'b00, 8'd0, DIV, 0);
    smp("rot7", 3'b001, 0, 3'b001, 3'd1, 0, 2'b00, 8'd0, DIV, 0);

    // Illegal code 111 trips on the third consecutive sample; no strobes while faulted.
    smp("h111_1", 3'b111, 0, 3'b001, 3'd1, 0, 2'b00, 8'd1, DIV, 0);
    smp("h111_2", 3'b111, 0, 3'b001, 3'd1, 0, 2'b00, 8'd2, DIV, 0);
    smp("h111_3", 3'b111, 0, 3'b001, 3'd1, 1, 2'b01, 8'd3, DIV, 0);
    repeat (3 * DIV) @(posedge clk);
    #2;
    do_ack();
    smp("resume1", 3'b001, 0, 3'b001, 3'd1, 0, 2'b00, 8'd3, DIV, 0);

    // Encoder error outranks the illegal code 000.
    smp("enc_1", 3'b000, 1, 3'b001, 3'd1, 0, 2'b00, 8'd4, DIV, 0);
    smp("enc_2", 3'b000, 1, 3'b001, 3'd1, 0, 2'b00, 8'd5, DIV, 0);
    smp("enc_3", 3'b000, 1, 3'b001, 3'd1, 1, 2'b10, 8'd6, DIV, 0);
    do_ack();
    smp("resume2", 3'b001, 0, 3'b001, 3'd1, 0, 2'b00, 8'd6, DIV, 0);

    // A good sample in between resets the consecutive count.
    smp("mix_bad1", 3'b111, 0, 3'b001, 3'd1, 0, 2'b00, 8'd7, DIV, 0);
    smp("mix_bad2", 3'b000, 0, 3'b001, 3'd1, 0, 2'b00, 8'd8, DIV, 0);
    smp("mix_good", 3'b011, 0, 3'b011, 3'd2, 0, 2'b00, 8'd8, DIV, 0);
    smp("mix_bad3", 3'b111, 0, 3'b011, 3'd2, 0, 2'b00, 8'd9, DIV, 0);
    smp("mix_bad4", 3'b111, 0, 3'b011, 3'd2, 0, 2'b00, 8'd10, DIV, 0);
    smp("mix_good2", 3'b011, 0, 3'b011, 3'd2, 0, 2'b00, 8'd10, DIV, 0);

    // Sector 1 followed by repeated sector 3 (a skipped step).
    smp("seq_s1", 3'b001, 0, 3'b001, 3'd1, 0, 2'b00, 8'd10, DIV, 0);
`ifdef HALL_SEQ_CHECK_EN
    smp("skip_1", 3'b010, 0, 3'b001, 3'd1, 0, 2'b00, 8'd11, DIV, 0);
    smp("skip_2", 3'b010, 0, 3'b001, 3'd1, 0, 2'b00, 8'd12, DIV, 0);
    smp("skip_3", 3'b010, 0, 3'b001, 3'd1, 1, 2'b11, 8'd13, DIV, 0);
    do_ack();
    eh = 3'b001; es = 3'd1; ee = 8'd13;
`else
    smp("skip_1", 3'b010, 0, 3'b010, 3'd3, 0, 2'b00, 8'd10, DIV, 0);
    smp("skip_2", 3'b010, 0, 3'b010, 3'd3, 0, 2'b00, 8'd10, DIV, 0);
    smp("skip_3", 3'b010, 0, 3'b010, 3'd3, 0, 2'b00, 8'd10, DIV, 0);
    eh = 3'b010; es = 3'd3; ee = 8'd10;
`endif

    // enable drops during SAMPLE: the sample still counts, then sampling stops.
    ee = ee + 8'd1;
    smp("en_drop", 3'b000, 1, eh, es, 0, 2'b00, ee, DIV, 1);
    repeat (3 * DIV) @(posedge clk);
    #2;
    bus.enable   = 1'b1;
    last_stb_cyc = cyc + 1;

    // Repeated trips until err_total saturates at 255; the last fault stays latched.
    g = DIV - 1;
    for (int r = 0; r < 90; r++) begin
      for (int j = 0; j < 3; j++) begin
        if (ee != 8'hFF) ee = ee + 8'd1;
        smp($sformatf("sat_%0d_%0d", r, j), 3'b111, 0, eh, es, (j == 2),
            (j == 2) ? 2'b01 : 2'b00, ee, g, 0);
        g = DIV;
      end
      if (r != 89) do_ack();
    end
    chk("err_saturated", bus.err_total, 8'hFF);

    // Asynchronous reset while faulted clears everything at once.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {bus.sample_stb, bus.hall_code, bus.sector, bus.fault,
                              bus.fault_code, bus.err_total}, 0);
    chk("async_rst_fault", bus.fault, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n        = 1'b1;
    last_stb_cyc = cyc + 1;
    #1;
    chk("post_rst_sector", bus.sector, 0);
    smp("post_rst_bad", 3'b111, 0, 3'b000, 3'd0, 0, 2'b00, 8'd1, DIV - 1, 0);
    smp("post_rst_good", 3'b100, 0, 3'b100, 3'd5, 0, 2'b00, 8'd1, DIV, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
